stuffed_serial_tx: RTL

Serial transmitter that produces the line stream consumed by the team's four-in-a-row sequence detector. It accepts a parallel word over a valid/ready handshake and emits one bit per clock on a single serial line. Each frame is a sync marker of four 1s, a 0 delimiter, then the data LSB-first with bit stuffing. Stuffing and idle toggling guarantee that a run of four identical bits occurs only at the sync marker.

---
 rtl/stuffed_serial_tx.sv | 107 ++++++++++
 1 files changed

// File: rtl/stuffed_serial_tx.sv
// Framed bit-stuffed serial transmitter: 4x1 marker, 0 delimiter, LSB-first payload; registered line, first bit 1 cycle after accept.
// Backpressure: tx_ready only in IDLE, one word per frame, tx_valid ignored while a frame is on the line.
`timescale 1ns/1ps
module stuffed_serial_tx #(
    parameter int DATA_W  = 8,
    parameter int RUN_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              tx_busy,
    output logic              frame_done
);
    localparam int IW = $clog2(DATA_W + 1);
    localparam int RW = $clog2(RUN_MAX + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
    localparam logic [IW-1:0] ALL_SENT = IW'(DATA_W);
    localparam logic [RW-1:0] RUN_LIM  = RW'(RUN_MAX);
    localparam logic [RW-1:0] RUN_ONE  = RW'(1);

    typedef enum logic [2:0] {IDLE, PRE, DELIM, DATA, STUFF} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     bit_idx;
    logic [RW-1:0]     run;
    logic [1:0]        pre_cnt;

    logic              data_bit;
    logic [RW-1:0]     send_run;
    logic              send_last;
    logic              frame_over;

    // bit_idx counts payload bits already put on the line
    always_comb begin
        data_bit   = shreg[0];
        send_run   = (data_bit == serial_out) ? run + RUN_ONE : RUN_ONE;
        send_last  = (bit_idx == LAST_IDX) && (send_run != RUN_LIM);
        frame_over = (bit_idx == ALL_SENT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            run        <= '0;
            pre_cnt    <= '0;
            serial_out <= 1'b0;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg      <= tx_data;
                        bit_idx    <= '0;
                        pre_cnt    <= '0;
                        state      <= PRE;
                        serial_out <= 1'b1;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                    end else begin
                        serial_out <= ~serial_out;
                    end
                end
                PRE: begin
                    serial_out <= (pre_cnt != 2'd3);
                    if (pre_cnt == 2'd3) begin
                        state <= DELIM;
                        run   <= RUN_ONE;
                    end else begin
                        pre_cnt <= pre_cnt + 2'd1;
                    end
                end
                DELIM, DATA, STUFF: begin
                    if (state == DATA && run == RUN_LIM) begin
                        // a stuff bit owed after the final data bit still ends the frame
                        state      <= STUFF;
                        serial_out <= ~serial_out;
                        run        <= RUN_ONE;
                        frame_done <= frame_over;
                    end else if (state != DELIM && frame_over) begin
                        state      <= IDLE;
                        serial_out <= ~serial_out;
                        run        <= '0;
                        frame_done <= 1'b0;
                        tx_busy    <= 1'b0;
                        tx_ready   <= 1'b1;
                    end else begin
                        state      <= DATA;
                        serial_out <= data_bit;
                        shreg      <= shreg >> 1;
                        bit_idx    <= bit_idx + IW'(1);
                        run        <= send_run;
                        frame_done <= send_last;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
